systolic_output_deskew: RTL and testbench

//  Receive end of the skewed systolic-array datapath: lane i of a result row arrives
//  i cycles after lane 0. Delay each lane by (NUM_LANES-1-i) enabled stages,

---
 rtl/systolic_output_deskew.sv | 166 ++++++++++++++++
 tb/tb_systolic_output_deskew.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew
//   Receive end of a skewed systolic-array datapath. Lane i of a result row
//   arrives i cycles after lane 0, so lane i is delayed by NUM_LANES-1-i
//   enable-gated stages. This lines every lane up into one row word. Aligned
//   rows are queued in a FIFO and drained downstream with valid/ready.
//
// Configuration macro: DESKEW_ERR_CHECK_EN
//   defined   : a row is pushed only when every aligned lane is valid. A row
//               that is only partly valid is dropped and sets err_misalign.
//               A row that arrives while the FIFO is full, with no pop in the
//               same cycle, is dropped and sets err_overflow.
//   undefined : a row is pushed on the valid of the last lane alone.
//               Overflowing rows are still dropped. Both error flags are held
//               at 0 and err_clear is ignored.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       global array stall; advances deskew stages and gates push
//   lane_valid   per-lane element valid (bit i = lane i)
//   lane_data    lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready     upstream may start a new row; reserves room for rows in flight
//   out_valid    out_data holds the FIFO head row
//   out_data     aligned row at the FIFO head, packed the same way as lane_data
//   out_ready    downstream accepts; pop on out_valid & out_ready
//   fifo_count   number of rows stored
//   err_misalign sticky: partly valid aligned row seen
//   err_overflow sticky: aligned row dropped because the FIFO was full
//   err_clear    synchronous clear of both sticky flags (a new error wins)
module systolic_output_deskew #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_LANES-1:0]             lane_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  lane_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  out_data,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             err_misalign,
    output logic                             err_overflow,
    input  logic                             err_clear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = NUM_LANES * DATA_WIDTH;

    logic [ROW_W-1:0]     aligned_data;
    logic [NUM_LANES-1:0] aligned_valid;

    // Deskew shift registers. Lane i has NUM_LANES-1-i stages, so lane 0 is
    // delayed the most and the last lane is not delayed at all.
    for (genvar i = 0; i < NUM_LANES - 1; i++) begin : g_lane
        localparam int DEPTH = NUM_LANES - 1 - i;

        logic [DATA_WIDTH-1:0] data_q [DEPTH];
        logic [DEPTH-1:0]      valid_q;

        // NOTE: registers are written with non-blocking assignments, so every
        // stage shifts from the value it held before the edge, whatever order
        // the statements are written in.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= '0;
                for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
            end else if (enable) begin
                data_q[0]  <= lane_data[i*DATA_WIDTH +: DATA_WIDTH];
                valid_q[0] <= lane_valid[i];
                for (int k = 1; k < DEPTH; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end

        assign aligned_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[DEPTH-1];
        assign aligned_valid[i]                         = valid_q[DEPTH-1];
    end

    // The last lane arrives last, so it joins the row straight from the input.
    assign aligned_data[(NUM_LANES-1)*DATA_WIDTH +: DATA_WIDTH] =
        lane_data[(NUM_LANES-1)*DATA_WIDTH +: DATA_WIDTH];
    assign aligned_valid[NUM_LANES-1] = lane_valid[NUM_LANES-1];

    // FIFO control
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push_req, push_ok, pop, full;

    assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop     = out_valid & out_ready;
    // When the FIFO is full, a pop in the same cycle frees the head slot,
    // and the write pointer points at that slot.
    assign push_ok = push_req & (~full | pop);

`ifdef DESKEW_ERR_CHECK_EN
    logic misalign_evt, overflow_evt;

    assign push_req     = enable & (&aligned_valid);
    assign misalign_evt = enable & (|aligned_valid) & ~(&aligned_valid);
    assign overflow_evt = push_req & full & ~pop;

    // A new error takes priority over err_clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_misalign <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (misalign_evt)   err_misalign <= 1'b1;
            else if (err_clear) err_misalign <= 1'b0;
            if (overflow_evt)   err_overflow <= 1'b1;
            else if (err_clear) err_overflow <= 1'b0;
        end
    end
`else
    logic unused_err_inputs;

    assign push_req          = enable & aligned_valid[NUM_LANES-1];
    assign err_misalign      = 1'b0;
    assign err_overflow      = 1'b0;
    assign unused_err_inputs = err_clear ^ (^aligned_valid[NUM_LANES-2:0]);
`endif

    // NOTE: count_next gets its default first, so every path through the
    // case assigns it and no latch is inferred.
    always_comb begin
        count_next = fifo_count;
        case ({push_ok, pop})
            2'b10:   count_next = fifo_count + CNT_W'(1);
            2'b01:   count_next = fifo_count - CNT_W'(1);
            default: count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
        end
    end

    // Row storage
    logic [ROW_W-1:0] mem [FIFO_DEPTH];

    // NOTE: the row storage has no reset. A slot is only read after it has
    // been written, and out_data is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= aligned_data;
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign in_ready  = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(NUM_LANES);

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Testbench for systolic_output_deskew (DATA_WIDTH=16, NUM_LANES=4,
// FIFO_DEPTH=8). Expected rows go into a queue when the last lane of a row
// is driven. A monitor pops the queue and compares against out_data on
// every accepted transfer.
module tb_systolic_output_deskew;

    localparam int DW    = 16;
    localparam int NL    = 4;
    localparam int DEPTH = 8;

`ifdef DESKEW_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NL-1:0]     lane_valid;
    logic [NL*DW-1:0]  lane_data;
    logic              in_ready;
    logic              out_valid;
    logic [NL*DW-1:0]  out_data;
    logic              out_ready;
    logic [3:0]        fifo_count;
    logic              err_misalign;
    logic              err_overflow;
    logic              err_clear;

    int                n_vec = 0;
    int                n_err = 0;
    logic [NL*DW-1:0]  exp_q [$];

    systolic_output_deskew #(.DATA_WIDTH(DW), .NUM_LANES(NL), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .lane_valid   (lane_valid),
        .lane_data    (lane_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .err_misalign (err_misalign),
        .err_overflow (err_overflow),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    // Lane i of the row tagged 'tag' carries {tag, i}.
    function automatic logic [NL*DW-1:0] row_word(input logic [7:0] tag);
        logic [NL*DW-1:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) w[i*DW +: DW] = {tag, 8'(i)};
        return w;
    endfunction

    // Scoreboard: every accepted transfer must match the oldest expected row.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_unexpected: got %h, no row expected", out_data);
                end else begin
                    logic [NL*DW-1:0] exp_row;
                    exp_row = exp_q.pop_front();
                    if (out_data !== exp_row) begin
                        n_err++;
                        $display("FAIL pop_data: got %h expected %h", out_data, exp_row);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        lane_valid = '0;
        lane_data  = '0;
    endtask

    // Drive one cycle of an n-row back-to-back stream. Lane i carries row t-i.
    task automatic stream_step(input int t, input int n, input logic [7:0] base);
        for (int i = 0; i < NL; i++) begin
            int r;
            r = t - i;
            if (r >= 0 && r < n) begin
                lane_valid[i]        = 1'b1;
                lane_data[i*DW +: DW] = {base + 8'(r), 8'(i)};
            end else begin
                lane_valid[i]        = 1'b0;
                lane_data[i*DW +: DW] = '0;
            end
        end
        if (t - (NL - 1) >= 0 && t - (NL - 1) < n && enable)
            exp_q.push_back(row_word(base + 8'(t - (NL - 1))));
        tick();
    endtask

    task automatic stream_rows(input int n, input logic [7:0] base);
        for (int t = 0; t < n + NL - 1; t++) stream_step(t, n, base);
        set_idle();
    endtask

    // Drive only lane i of the row 'tag' for one cycle.
    task automatic single_lane(input int i, input logic [7:0] tag);
        set_idle();
        lane_valid[i]         = 1'b1;
        lane_data[i*DW +: DW] = {tag, 8'(i)};
        tick();
    endtask

    task automatic check_count(input string name, input int exp_cnt);
        n_vec++;
        if (fifo_count !== 4'(exp_cnt)) begin
            n_err++;
            $display("FAIL %s: fifo_count got %0d expected %0d", name, fifo_count, exp_cnt);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && k < 50) begin
            tick();
            k++;
        end
        n_vec++;
        if (k >= 50) begin
            n_err++;
            $display("FAIL %s_timeout: %0d rows left, out_valid=%b", name, exp_q.size(), out_valid);
        end
        check_count({name, "_empty"}, 0);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; out_ready = 1'b0; err_clear = 1'b0;
        set_idle();
        #12;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b data=%h in_ready=%b expected 0/0/1",
                     out_valid, out_data, in_ready);
        end
        check_count("reset_count", 0);
        n_vec++;
        if (err_misalign !== 1'b0 || err_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_errs: mis=%b ovf=%b expected 0/0", err_misalign, err_overflow);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_row();
        int vcnt;
        out_ready = 1'b1;
        stream_rows(1, 8'h0A);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 64'h0A03_0A02_0A01_0A00) begin
            n_err++;
            $display("FAIL single_row: valid=%b data=%h expected 1/0a030a020a010a00",
                     out_valid, out_data);
        end
        vcnt = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid) vcnt++;
        end
        n_vec++;
        if (vcnt !== 1) begin
            n_err++;
            $display("FAIL single_row_valid_cycles: got %0d expected 1", vcnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int t = 0; t < 8 + NL - 1; t++) begin
            int exp_cnt;
            stream_step(t, 8, 8'h10);
            exp_cnt = (t - 2 < 0) ? 0 : ((t - 2 > 8) ? 8 : t - 2);
            check_count("b2b_count", exp_cnt);
            n_vec++;
            if (in_ready !== ((DEPTH - exp_cnt) >= NL)) begin
                n_err++;
                $display("FAIL b2b_in_ready: got %b at count %0d", in_ready, exp_cnt);
            end
        end
        set_idle();
        drain("b2b_drain");
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        enable    = 1'b1;
        single_lane(0, 8'h30);
        single_lane(1, 8'h30);
        enable = 1'b0;
        // Last-lane valid while stalled must not push a row.
        single_lane(3, 8'hEE);
        set_idle();
        tick();
        tick();
        check_count("stall_no_push", 0);
        enable = 1'b1;
        single_lane(2, 8'h30);
        exp_q.push_back(row_word(8'h30));
        single_lane(3, 8'h30);
        set_idle();
        check_count("stall_resume_count", 1);
        n_vec++;
        if (out_data !== row_word(8'h30)) begin
            n_err++;
            $display("FAIL stall_resume_data: got %h expected %h", out_data, row_word(8'h30));
        end
        drain("stall_drain");
    endtask

    task automatic test_misalign();
        out_ready = 1'b1;
        single_lane(0, 8'h40);
        single_lane(1, 8'h40);
        set_idle();
        lane_data[2*DW +: DW] = {8'h40, 8'd2};
        tick();
        if (!ERR_EN) exp_q.push_back(row_word(8'h40));
        single_lane(3, 8'h40);
        set_idle();
        check_count("misalign_count", ERR_EN ? 0 : 1);
        n_vec++;
        if (err_misalign !== ERR_EN) begin
            n_err++;
            $display("FAIL misalign_flag: got %b expected %b", err_misalign, ERR_EN);
        end
        tick();
        tick();
        n_vec++;
        if (err_misalign !== ERR_EN) begin
            n_err++;
            $display("FAIL misalign_sticky: got %b expected %b", err_misalign, ERR_EN);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_vec++;
        if (err_misalign !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_clear: got %b expected 0", err_misalign);
        end
        // A new misalign in the same cycle as err_clear must win.
        single_lane(0, 8'h41);
        single_lane(1, 8'h41);
        set_idle();
        tick();
        if (!ERR_EN) exp_q.push_back({{8'h41, 8'd3}, 16'h0000, {8'h41, 8'd1}, {8'h41, 8'd0}});
        err_clear = 1'b1;
        single_lane(3, 8'h41);
        err_clear = 1'b0;
        set_idle();
        n_vec++;
        if (err_misalign !== ERR_EN) begin
            n_err++;
            $display("FAIL misalign_set_wins: got %b expected %b", err_misalign, ERR_EN);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        drain("misalign_drain");
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        stream_rows(8, 8'h50);
        check_count("full_fill", 8);
        // Push and pop on the same edge while full.
        single_lane(0, 8'h60);
        single_lane(1, 8'h60);
        single_lane(2, 8'h60);
        out_ready = 1'b1;
        exp_q.push_back(row_word(8'h60));
        single_lane(3, 8'h60);
        out_ready = 1'b0;
        set_idle();
        check_count("full_push_pop", 8);
        n_vec++;
        if (err_overflow !== 1'b0 || out_data !== row_word(8'h51)) begin
            n_err++;
            $display("FAIL full_push_pop_state: ovf=%b head=%h expected 0/%h",
                     err_overflow, out_data, row_word(8'h51));
        end
        // Row arrives while full with no pop: dropped.
        for (int i = 0; i < NL; i++) single_lane(i, 8'h70);
        set_idle();
        check_count("overflow_count", 8);
        n_vec++;
        if (err_overflow !== ERR_EN) begin
            n_err++;
            $display("FAIL overflow_flag: got %b expected %b", err_overflow, ERR_EN);
        end
        drain("full_drain");
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_vec++;
        if (err_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: got %b expected 0", err_overflow);
        end
    endtask

    task automatic test_reset_mid_row();
        out_ready = 1'b0;
        stream_rows(3, 8'h80);
        check_count("midreset_fill", 3);
        single_lane(0, 8'h90);
        single_lane(1, 8'h90);
        set_idle();
        reset = 1'b0;
        #1;
        exp_q.delete();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: valid=%b in_ready=%b data=%h expected 0/1/0",
                     out_valid, in_ready, out_data);
        end
        check_count("midreset_count", 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_count("midreset_no_push", 0);
        n_vec++;
        if (out_valid !== 1'b0 || err_misalign !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_quiet: valid=%b mis=%b expected 0/0", out_valid, err_misalign);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_stall();
        test_misalign();
        test_full();
        test_reset_mid_row();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
